dispatcher: RTL and testbench
=============================

// Module: dispatcher
// PURPOSE
//  Transmit-side counterpart of the NoC collector. Accepts DATAW-wide words from a local
//  producer (MVM tile output) into a DEPTH-entry FIFO, groups them into PKT_LEN-flit packets
//  and drives them onto an AXI-Stream tx port toward the NoC router. tdest rotates
//  round-robin over NUM_DEST consecutive router endpoints, one packet per destination.
// PARAMETERS
//  DATAW     512  axi-s tdata width / FIFO word width
//  BYTEW     8    tkeep/tstrb width
//  IDW       32   tid width
//  DESTW     7    tdest width
//  USERW     75   tuser width (>=16)
//  DEPTH     64   FIFO entries (power of 2, >= 2*PKT_LEN)
//  PKT_LEN   4    flits per full packet (>=1)
//  SRC_ID    0    value driven on tid
//  DEST_BASE 0    first destination endpoint
//  NUM_DEST  4    destinations in the rotation (>=1, DEST_BASE+NUM_DEST-1 < 2**DESTW)
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, asynchronous, active-high
//  data_fifo_wen   in   1      push request; accepted only when data_fifo_rdy=1
//  data_fifo_wdata in   DATAW  push data
//  data_fifo_rdy   out  1      FIFO can accept a word this cycle
//  flush           in   1      level; allows a short packet when fewer than PKT_LEN words queued
//  overflow        out  1      sticky: wen seen while rdy=0 (word dropped)
//  axis_tx_tvalid  out  1      axi-s valid
//  axis_tx_tdata   out  DATAW  axi-s data = FIFO head
//  axis_tx_tstrb   out  BYTEW  all ones
//  axis_tx_tkeep   out  BYTEW  all ones
//  axis_tx_tid     out  IDW    SRC_ID
//  axis_tx_tdest   out  DESTW  DEST_BASE + dest_idx
//  axis_tx_tuser   out  USERW  [15:0] packet sequence number, upper bits 0
//  axis_tx_tlast   out  1      last flit of packet
//  axis_tx_tready  in   1      axi-s ready from router
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, occupancy 0, FSM IDLE, dest_idx 0, seq 0,
//   tvalid 0, tlast 0, overflow 0, data_fifo_rdy 0 while rst=1, 1 after release.
//  data_fifo_rdy = (occupancy <= DEPTH-3), i.e. 2-entry almost-full margin.
//  Push at edge when wen&&rdy; wen&&!rdy drops the word and sets overflow (cleared only by rst).
//  Pop at edge when tvalid&&tready. Push+pop in same cycle: occupancy unchanged.
//  FSM IDLE: if occupancy>=PKT_LEN -> SEND with len=PKT_LEN;
//   else if flush && occupancy>0 -> SEND with len=occupancy (latched); else stay.
//   Transition at next edge; tvalid=1 registered with it (PKT_LEN-th push at edge E ->
//   tvalid high after edge E+1). Pushes during SEND do not change the latched len.
//  FSM SEND: tvalid=1 every cycle (a packet is only started when all its flits are queued,
//   so tvalid never drops mid-packet). flit counter 0..len-1; tlast=(cnt==len-1).
//   tdata/tdest/tuser/tlast held stable while tvalid&&!tready.
//   On tlast handshake: dest_idx wraps NUM_DEST-1 -> 0, seq+1 mod 2**16, -> IDLE
//   (one idle cycle between packets, tvalid=0 for that cycle).
//  tdest constant for all flits of a packet; tid, tstrb, tkeep constant.
//  rst mid-packet: packet abandoned, queued data discarded, no tlast emitted.
// TESTING
//  1. Push 4 words A0..A3 back-to-back, tready=1 -> 4 flits, tdest 0,0,0,0, tlast on A3, tuser=0; tvalid rises 1 cycle after A3 push.
//  2. Push 20 words, tready=1 -> 5 packets, tdest 0,1,2,3,0, tuser 0..4, one idle cycle between packets.
//  3. Push 3 words, no flush -> tvalid stays 0; assert flush -> 3-flit packet, tlast on 3rd.
//  4. tready=0 for 10 cycles mid-packet -> tdata/tlast/tdest stable; no flit lost or duplicated.
//  5. tready=0, push 70 words -> rdy falls at occupancy 62, overflow=1 after extra wen; 62 words later drain in order.
//  6. Assert rst during flit 2 of a packet -> tvalid 0 same cycle, after release rdy=1, dest_idx 0, seq 0.

Source files
------------

// File: rtl/dispatcher_if.sv
// Producer push port plus AXI-Stream tx port of the dispatcher.
// The slave modport is the dispatcher. The master modport is whoever feeds words and sinks flits.
interface dispatcher_if #(
  parameter int DATAW = 512,
  parameter int BYTEW = 8,
  parameter int IDW   = 32,
  parameter int DESTW = 7,
  parameter int USERW = 75
);
  logic             data_fifo_wen;
  logic [DATAW-1:0] data_fifo_wdata;
  logic             data_fifo_rdy;
  logic             flush;
  logic             overflow;
  logic             axis_tx_tvalid;
  logic [DATAW-1:0] axis_tx_tdata;
  logic [BYTEW-1:0] axis_tx_tstrb;
  logic [BYTEW-1:0] axis_tx_tkeep;
  logic [IDW-1:0]   axis_tx_tid;
  logic [DESTW-1:0] axis_tx_tdest;
  logic [USERW-1:0] axis_tx_tuser;
  logic             axis_tx_tlast;
  logic             axis_tx_tready;

  modport master (
    output data_fifo_wen, data_fifo_wdata, flush, axis_tx_tready,
    input  data_fifo_rdy, overflow, axis_tx_tvalid, axis_tx_tdata, axis_tx_tstrb,
           axis_tx_tkeep, axis_tx_tid, axis_tx_tdest, axis_tx_tuser, axis_tx_tlast
  );

  modport slave (
    input  data_fifo_wen, data_fifo_wdata, flush, axis_tx_tready,
    output data_fifo_rdy, overflow, axis_tx_tvalid, axis_tx_tdata, axis_tx_tstrb,
           axis_tx_tkeep, axis_tx_tid, axis_tx_tdest, axis_tx_tuser, axis_tx_tlast
  );
endinterface

// File: rtl/dispatcher.sv
// Packs queued words into PKT_LEN-flit AXI-Stream packets, with tdest rotating over NUM_DEST endpoints.
// tvalid rises one cycle after a packet is fully queued. tready stalls hold the flit, and rdy drops with a 2-entry margin.
module dispatcher #(
  parameter int DATAW     = 512,
  parameter int BYTEW     = 8,
  parameter int IDW       = 32,
  parameter int DESTW     = 7,
  parameter int USERW     = 75,
  parameter int DEPTH     = 64,
  parameter int PKT_LEN   = 4,
  parameter int SRC_ID    = 0,
  parameter int DEST_BASE = 0,
  parameter int NUM_DEST  = 4
) (
  input  logic         clk,
  input  logic         rst,
  dispatcher_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [AW:0]      RDY_MAX     = (AW+1)'(DEPTH-3);
  localparam logic [AW:0]      PKT_LEN_W   = (AW+1)'(PKT_LEN);
  localparam logic [AW:0]      OCC_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE     = AW'(1);
  localparam logic [DESTW-1:0] LAST_DEST   = DESTW'(NUM_DEST-1);
  localparam logic [DESTW-1:0] DEST_ONE    = DESTW'(1);
  localparam logic [DESTW-1:0] DEST_BASE_W = DESTW'(DEST_BASE);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ, len, cnt;
  logic [0:0]       state;
  logic [DESTW-1:0] dest_idx;
  logic [15:0]      seq;
  logic             overflow_q;
  logic             push, pop, tvalid, tlast;

  assign bus.data_fifo_rdy = !rst && (occ <= RDY_MAX);
  assign push   = bus.data_fifo_wen && bus.data_fifo_rdy;
  assign tvalid = (state == SEND);
  assign tlast  = tvalid && (cnt == len - OCC_ONE);
  assign pop    = tvalid && bus.axis_tx_tready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_fifo_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: ;
      endcase
      if (bus.data_fifo_wen && !bus.data_fifo_rdy) overflow_q <= 1'b1;
    end
  end

  // A packet only starts once every flit is queued, so SEND never starves mid-packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      cnt      <= '0;
      dest_idx <= '0;
      seq      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (occ >= PKT_LEN_W) begin
            state <= SEND;
            len   <= PKT_LEN_W;
          end else if (bus.flush && (occ != '0)) begin
            state <= SEND;
            len   <= occ;
          end
        end
        SEND: begin
          if (pop) begin
            if (tlast) begin
              state    <= IDLE;
              cnt      <= '0;
              dest_idx <= (dest_idx == LAST_DEST) ? '0 : dest_idx + DEST_ONE;
              seq      <= seq + 16'd1;
            end else begin
              cnt <= cnt + OCC_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.overflow       = overflow_q;
  assign bus.axis_tx_tvalid = tvalid;
  assign bus.axis_tx_tdata  = mem[rd_ptr];
  assign bus.axis_tx_tstrb  = '1;
  assign bus.axis_tx_tkeep  = '1;
  assign bus.axis_tx_tid    = IDW'(SRC_ID);
  assign bus.axis_tx_tdest  = DEST_BASE_W + dest_idx;
  assign bus.axis_tx_tuser  = USERW'(seq);
  assign bus.axis_tx_tlast  = tlast;
endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher: packetization, rotation, flush, stall, overflow and mid-packet reset.
module tb_dispatcher;
  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_dest   = 0;
  int   exp_seq    = 0;
  int   accepted;

  dispatcher_if bus ();

  dispatcher dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] word(input int tag, input int i);
    logic [15:0] t = 16'(tag);
    logic [15:0] n = 16'(i);
    return {16{t, n}};
  endfunction

  // Entered and left on a falling edge, with one word pushed per cycle.
  task automatic push_words(input int tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.data_fifo_wen   = 1'b1;
      bus.data_fifo_wdata = word(tag, i);
      @(negedge clk);
    end
    bus.data_fifo_wen = 1'b0;
  endtask

  task automatic get_flit(input logic [511:0] d, input bit last, input string tag);
    int n = 0;
    while (!bus.axis_tx_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " tvalid"}, bus.axis_tx_tvalid, 1'b1);
    chk({tag, " tdata"},  bus.axis_tx_tdata, d);
    chk({tag, " tdest"},  bus.axis_tx_tdest, 7'(exp_dest));
    chk({tag, " tuser"},  bus.axis_tx_tuser, 75'(exp_seq));
    chk({tag, " tlast"},  bus.axis_tx_tlast, last);
    @(negedge clk);
    if (last) chk({tag, " idle gap"}, bus.axis_tx_tvalid, 1'b0);
  endtask

  task automatic recv_pkt(input int tag, input int first, input int n);
    for (int f = 0; f < n; f++)
      get_flit(word(tag, first + f), f == n - 1, $sformatf("t%0d w%0d", tag, first + f));
    exp_dest = (exp_dest + 1) % 4;
    exp_seq  = (exp_seq + 1) % 65536;
  endtask

  initial begin
    rst = 1'b1;
    bus.data_fifo_wen   = 1'b0;
    bus.data_fifo_wdata = '0;
    bus.flush           = 1'b0;
    bus.axis_tx_tready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst rdy", bus.data_fifo_rdy, 1'b0);
    chk("rst tvalid", bus.axis_tx_tvalid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post rst rdy", bus.data_fifo_rdy, 1'b1);
    chk("post rst overflow", bus.overflow, 1'b0);
    chk("post rst tlast", bus.axis_tx_tlast, 1'b0);
    chk("tid", bus.axis_tx_tid, 32'd0);
    chk("tkeep", bus.axis_tx_tkeep, 8'hff);
    chk("tstrb", bus.axis_tx_tstrb, 8'hff);
    @(negedge clk);

    // 1: one full packet and its start latency
    bus.axis_tx_tready = 1'b1;
    push_words(1, 4);
    chk("t1 tvalid low after 4th push", bus.axis_tx_tvalid, 1'b0);
    @(negedge clk);
    chk("t1 tvalid high next cycle", bus.axis_tx_tvalid, 1'b1);
    recv_pkt(1, 0, 4);

    // 2: five packets while pushing, with tdest rotation
    fork
      push_words(2, 20);
      for (int p = 0; p < 5; p++) recv_pkt(2, 4 * p, 4);
    join

    // 3: short packet only on flush
    push_words(3, 3);
    repeat (5) @(negedge clk);
    chk("t3 no flush tvalid", bus.axis_tx_tvalid, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("t3 flush tvalid", bus.axis_tx_tvalid, 1'b1);
    recv_pkt(3, 0, 3);
    bus.flush = 1'b0;

    // 4: mid-packet stall holds the flit
    push_words(4, 4);
    get_flit(word(4, 0), 1'b0, "t4 w0");
    bus.axis_tx_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t4 stall tdata", bus.axis_tx_tdata, word(4, 1));
      chk("t4 stall tlast", bus.axis_tx_tlast, 1'b0);
      chk("t4 stall tdest", bus.axis_tx_tdest, 7'(exp_dest));
      @(negedge clk);
    end
    bus.axis_tx_tready = 1'b1;
    for (int f = 1; f < 4; f++) get_flit(word(4, f), f == 3, "t4 drain");
    exp_dest = (exp_dest + 1) % 4;
    exp_seq  = exp_seq + 1;

    // 5: fill to the almost-full margin, then overflow
    bus.axis_tx_tready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 70; i++) begin
      if (i == 62) begin
        chk("t5 rdy low at 62", bus.data_fifo_rdy, 1'b0);
        chk("t5 no overflow yet", bus.overflow, 1'b0);
      end
      if (bus.data_fifo_rdy) accepted++;
      bus.data_fifo_wen   = 1'b1;
      bus.data_fifo_wdata = word(5, i);
      @(negedge clk);
    end
    bus.data_fifo_wen = 1'b0;
    chk("t5 accepted", 32'(accepted), 32'd62);
    chk("t5 overflow", bus.overflow, 1'b1);
    bus.axis_tx_tready = 1'b1;
    bus.flush = 1'b1;
    for (int p = 0; p < 15; p++) recv_pkt(5, 4 * p, 4);
    recv_pkt(5, 60, 2);
    bus.flush = 1'b0;
    chk("t5 overflow sticky", bus.overflow, 1'b1);

    // 6: reset during flit 2 discards the packet and the queue
    push_words(6, 4);
    get_flit(word(6, 0), 1'b0, "t6 w0");
    chk("t6 flit2 shown", bus.axis_tx_tdata, word(6, 1));
    rst = 1'b1;
    #1;
    chk("t6 rst tvalid", bus.axis_tx_tvalid, 1'b0);
    chk("t6 rst rdy", bus.data_fifo_rdy, 1'b0);
    chk("t6 rst overflow", bus.overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6 rdy after release", bus.data_fifo_rdy, 1'b1);
    chk("t6 tvalid after release", bus.axis_tx_tvalid, 1'b0);
    exp_dest = 0;
    exp_seq  = 0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6 queue discarded", bus.axis_tx_tvalid, 1'b0);
    push_words(7, 4);
    recv_pkt(7, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
